axis_rr_arbiter: RTL and testbench

//  Packet-level round-robin arbiter sharing one AXI-Stream slave (e.g. axis_s) between NUM_SRC
//  AXI-Stream masters (e.g. axis_m instances). Grants one source per packet, holds grant until
//  the tlast beat completes, then rotates priority. Sits between stream producers and the single

---
 rtl/axis_rr_arbiter.sv | 117 +++++++++++
 tb/tb_axis_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: shares one AXI-Stream slave between NUM_SRC masters,
// holding each grant until the tlast beat and rotating priority after every packet.
module axis_rr_arbiter #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16
) (
   input  logic                      axis_aclk,
   input  logic                      axis_aresetn,
   input  logic [NUM_SRC-1:0]        s_axis_tvalid,
   input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]        s_axis_tlast,
   output logic [NUM_SRC-1:0]        s_axis_tready,
   output logic                      m_axis_tvalid,
   output logic [DATA_W-1:0]         m_axis_tdata,
   output logic                      m_axis_tlast,
   output logic [ID_W-1:0]           m_axis_tid,
   input  logic                      m_axis_tready,
   output logic                      busy,
   output logic [CNT_W-1:0]          pkt_cnt
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;
   logic              req_found;
   logic [ID_W-1:0]   req_idx;
   logic [ID_W-1:0]   scan_idx;

   // Source selected by the current grant
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == ID_W'(i)) begin
            sel_valid = s_axis_tvalid[i];
            sel_last  = s_axis_tlast[i];
            sel_data  = s_axis_tdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // Scan starts just after the last granted source, wrapping modulo NUM_SRC
   always_comb begin
      req_found = 1'b0;
      req_idx   = last_grant_q;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         scan_idx = ID_W'((int'(last_grant_q) + k) % NUM_SRC);
         if (!req_found && s_axis_tvalid[scan_idx]) begin
            req_found = 1'b1;
            req_idx   = scan_idx;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      pkt_cnt_d     = pkt_cnt_q;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      busy          = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_found) begin
               grant_d = req_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            busy                   = 1'b1;
            m_axis_tvalid          = sel_valid;
            m_axis_tdata           = sel_data;
            m_axis_tlast           = sel_last;
            s_axis_tready[grant_q] = m_axis_tready;
            if (sel_valid && m_axis_tready && sel_last) begin
               state_d      = IDLE;
               last_grant_d = grant_q;
               pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // last_grant resets to the top index so the first scan after reset begins at source 0
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= ID_W'(NUM_SRC - 1);
         pkt_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         pkt_cnt_q    <= pkt_cnt_d;
      end
   end

   assign m_axis_tid = grant_q;
   assign pkt_cnt    = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-source beat queues feed the DUT; a packet-level model predicts
// every output each cycle, and a second instance with a 2-bit counter exercises counter wrap.
module tb_axis_rr_arbiter;
   localparam int NS = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [NS-1:0]     s_tvalid, s_tlast;
   logic [NS*DW-1:0]  s_tdata;
   logic              m_tready;

   logic [NS-1:0]     s_tready_a, s_tready_b;
   logic              m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b, busy_a, busy_b;
   logic [DW-1:0]     m_tdata_a, m_tdata_b;
   logic [IW-1:0]     m_tid_a, m_tid_b;
   logic [15:0]       pkt_cnt_a;
   logic [1:0]        pkt_cnt_b;

   axis_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW), .CNT_W(16)) u_dut (
      .axis_aclk(clk), .axis_aresetn(rst_n),
      .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready_a),
      .m_axis_tvalid(m_tvalid_a), .m_axis_tdata(m_tdata_a), .m_axis_tlast(m_tlast_a),
      .m_axis_tid(m_tid_a), .m_axis_tready(m_tready),
      .busy(busy_a), .pkt_cnt(pkt_cnt_a));

   axis_rr_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .ID_W(IW), .CNT_W(2)) u_dut_w (
      .axis_aclk(clk), .axis_aresetn(rst_n),
      .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready_b),
      .m_axis_tvalid(m_tvalid_b), .m_axis_tdata(m_tdata_b), .m_axis_tlast(m_tlast_b),
      .m_axis_tid(m_tid_b), .m_axis_tready(m_tready),
      .busy(busy_b), .pkt_cnt(pkt_cnt_b));

   logic [8:0] mem [NS][1024];
   int head [NS];
   int tail [NS];

   int vecs = 0;
   int errs = 0;
   int m_owner, m_grant, m_last;
   int unsigned m_cnt;
   int first_tid;
   int obs_beats = 0;
   int tot_beats = 0;
   logic [31:0] ord_log;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NS; i++) begin
         if (head[i] < tail[i]) begin
            s_tvalid[i]           = 1'b1;
            s_tdata[i*DW +: DW]   = mem[i][head[i]][7:0];
            s_tlast[i]            = mem[i][head[i]][8];
         end else begin
            s_tvalid[i]           = 1'b0;
            s_tdata[i*DW +: DW]   = '0;
            s_tlast[i]            = 1'b0;
         end
      end
   endtask

   task automatic push_beat(input int s, input logic [7:0] d, input logic l);
      mem[s][tail[s]] = {l, d};
      tail[s]++;
      tot_beats++;
   endtask

   task automatic push_pkt(input int s, input int len);
      for (int b = 0; b < len; b++) push_beat(s, 8'($urandom), b == len - 1);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_grant = 0;
      m_last  = NS - 1;
      m_cnt   = 0;
   endtask

   // One clock: compare at the falling edge, advance the model, then drive after the rising edge
   task automatic cycle();
      logic [NS-1:0] exp_rdy;
      logic          ev, el, ebusy, beat, found;
      logic [7:0]    ed;
      int            g, idx;
      @(negedge clk);
      exp_rdy = '0; ev = 1'b0; el = 1'b0; ed = '0; beat = 1'b0; g = 0;
      ebusy = (m_owner >= 0);
      if (m_owner >= 0) begin
         g          = m_owner;
         ev         = s_tvalid[g];
         ed         = s_tdata[g*DW +: DW];
         el         = s_tlast[g];
         exp_rdy[g] = m_tready;
         beat       = ev && m_tready;
      end
      chk("m_tvalid", {31'd0, m_tvalid_a}, {31'd0, ev});
      chk("m_tdata", {24'd0, m_tdata_a}, {24'd0, ed});
      chk("m_tlast", {31'd0, m_tlast_a}, {31'd0, el});
      chk("m_tid", {30'd0, m_tid_a}, 32'(m_grant));
      chk("s_tready", {28'd0, s_tready_a}, {28'd0, exp_rdy});
      chk("busy", {31'd0, busy_a}, {31'd0, ebusy});
      chk("pkt_cnt", {16'd0, pkt_cnt_a}, {16'd0, m_cnt[15:0]});
      chk("w_m_tvalid", {31'd0, m_tvalid_b}, {31'd0, ev});
      chk("w_m_tdata", {24'd0, m_tdata_b}, {24'd0, ed});
      chk("w_s_tready", {28'd0, s_tready_b}, {28'd0, exp_rdy});
      chk("w_pkt_cnt", {30'd0, pkt_cnt_b}, {30'd0, m_cnt[1:0]});
      if (m_tvalid_a && first_tid < 0) first_tid = int'(m_tid_a);
      if (m_tvalid_a && m_tready) begin
         obs_beats++;
         if (m_tlast_a) ord_log = (ord_log << 4) | {30'd0, m_tid_a};
      end
      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= NS; k++) begin
            idx = (m_last + k) % NS;
            if (!found && s_tvalid[idx]) begin
               found   = 1'b1;
               m_owner = idx;
               m_grant = idx;
            end
         end
      end else if (beat) begin
         head[g]++;
         if (el) begin
            m_last  = g;
            m_owner = -1;
            m_cnt++;
         end
      end
      @(posedge clk);
      #1;
      drive_inputs();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", {31'd0, m_tvalid_a}, 32'd0);
      chk("rst_m_tdata", {24'd0, m_tdata_a}, 32'd0);
      chk("rst_m_tlast", {31'd0, m_tlast_a}, 32'd0);
      chk("rst_m_tid", {30'd0, m_tid_a}, 32'd0);
      chk("rst_s_tready", {28'd0, s_tready_a}, 32'd0);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_pkt_cnt", {16'd0, pkt_cnt_a}, 32'd0);
      chk("rst_w_pkt_cnt", {30'd0, pkt_cnt_b}, 32'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_inputs();
   endtask

   task automatic drain(input int budget);
      m_tready = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (m_owner < 0 && head[0] == tail[0] && head[1] == tail[1] &&
             head[2] == tail[2] && head[3] == tail[3]) break;
         cycle();
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout vectors=%0d", vecs);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] pat;
      for (int i = 0; i < NS; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      rst_n    = 1'b1;
      m_tready = 1'b0;
      ord_log  = '0;
      first_tid = -1;
      drive_inputs();
      #1;
      do_reset();

      // T1: four-beat packet from source 0
      push_beat(0, 8'hAA, 1'b0);
      push_beat(0, 8'hAB, 1'b0);
      push_beat(0, 8'hAC, 1'b0);
      push_beat(0, 8'hAD, 1'b1);
      drive_inputs();
      m_tready  = 1'b1;
      first_tid = -1;
      for (int c = 0; c < 6; c++) cycle();
      chk("t1_pkt_cnt", {16'd0, pkt_cnt_a}, 32'd1);
      chk("t1_busy_low", {31'd0, busy_a}, 32'd0);
      chk("t1_tid", 32'(first_tid), 32'd0);
      chk("t1_beats", 32'(obs_beats), 32'd4);

      // T2: all sources hold 3-beat packets
      do_reset();
      for (int s = 0; s < NS; s++) push_pkt(s, 3);
      drive_inputs();
      ord_log = '0;
      drain(100);
      chk("t2_order", ord_log, 32'h0123);
      chk("t2_pkt_cnt", {16'd0, pkt_cnt_a}, 32'd4);

      // T3: source 1 under a stalling sink
      do_reset();
      push_pkt(1, 4);
      drive_inputs();
      pat = 7'b1001011;
      for (int p = 0; p < 7; p++) begin
         m_tready = pat[p];
         cycle();
      end
      drain(50);
      chk("t3_pkt_cnt", {16'd0, pkt_cnt_a}, 32'd1);

      // T4: last grant 2, then sources 1 and 3 compete
      do_reset();
      push_pkt(2, 1);
      drive_inputs();
      drain(20);
      ord_log = '0;
      push_pkt(1, 2);
      push_pkt(3, 2);
      drive_inputs();
      drain(50);
      chk("t4_order", ord_log, 32'h31);

      // T5: reset mid-packet from source 2
      do_reset();
      push_pkt(2, 4);
      drive_inputs();
      m_tready = 1'b1;
      for (int c = 0; c < 3; c++) cycle();
      do_reset();
      push_pkt(0, 2);
      drive_inputs();
      first_tid = -1;
      ord_log   = '0;
      drain(50);
      chk("t5_first_tid", 32'(first_tid), 32'd0);
      chk("t5_order", ord_log, 32'h02);

      // T6: counter wrap on the 2-bit instance
      do_reset();
      for (int n = 0; n < 5; n++) begin
         push_pkt(0, 1);
         drive_inputs();
         drain(20);
      end
      chk("t6_w_pkt_cnt", {30'd0, pkt_cnt_b}, 32'd1);
      chk("t6_pkt_cnt", {16'd0, pkt_cnt_a}, 32'd5);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            int s;
            s = $urandom_range(0, NS - 1);
            if (tail[s] < 1000) push_pkt(s, $urandom_range(1, 4));
         end
         m_tready = ($urandom_range(0, 3) != 0);
         drive_inputs();
         cycle();
      end
      drain(3000);
      chk("all_beats_delivered", 32'(obs_beats), 32'(tot_beats));
      chk("final_busy", {31'd0, busy_a}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
